// File: rtl/aes_decrypt_sequencer.sv
// aes_decrypt_sequencer
// Iterative control for an external combinational AES inverse-round unit.
// Accepts one ciphertext block, applies the initial AddRoundKey, then walks
// the round keys from rk[ROUNDS-1] down to rk0 (one round per cycle). It holds
// the plaintext until the consumer takes it.
// Optional build macro: AES_DEC_KEY_LATCH_EN. When it is defined, key_chain_i is
// captured on the accept edge, so the key source is free to change while a
// block is in flight. When it is not defined, round keys come straight from
// key_chain_i, which must stay stable until out_valid_o rises.
module aes_decrypt_sequencer #(
  parameter int ROUNDS = 14
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [127:0]              ciphertext_i,
  input  logic [128*(ROUNDS+1)-1:0] key_chain_i,
  output logic [127:0]              round_state_o,
  output logic [127:0]              round_key_o,
  output logic                      round_mix_en_o,
  input  logic [127:0]              round_result_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [127:0]              plaintext_o,
  output logic                      busy_o,
  output logic [3:0]                round_o
);

  localparam int KW = 128 * (ROUNDS + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_DONE  = 2'd2
  } fsm_e;

  fsm_e         fsm_q;
  logic [127:0] state_q;
  logic [3:0]   cnt_q;
  logic         ready_q;
  logic         valid_q;
  logic         busy_q;
  logic         accept_d;
  logic [KW-1:0] key_src;
  logic [127:0] rk [ROUNDS+1];

  assign accept_d = (fsm_q == S_IDLE) && ready_q && in_valid_i;

`ifdef AES_DEC_KEY_LATCH_EN
  logic [KW-1:0] key_q;

  // Snapshot the whole key chain when a block is accepted
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      key_q <= '0;
    end else if (accept_d) begin
      key_q <= key_chain_i;
    end
  end

  assign key_src = key_q;
`else
  assign key_src = key_chain_i;
`endif

  // rk0 sits at the MSBs of the chain, rk[ROUNDS] at the LSBs
  for (genvar k = 0; k <= ROUNDS; k++) begin : g_rk
    assign rk[k] = key_src[KW-1-128*k -: 128];
  end

  // Sequencer FSM: accept, iterate rounds, hold result until taken
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      fsm_q   <= S_IDLE;
      state_q <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (fsm_q)
        S_IDLE: begin
          if (accept_d) begin
            // Initial AddRoundKey with the last round key (chain LSBs).
            state_q <= ciphertext_i ^ key_chain_i[127:0];
            cnt_q   <= 4'(ROUNDS - 1);
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            fsm_q   <= S_ROUND;
          end else begin
            ready_q <= 1'b1;
          end
        end
        S_ROUND: begin
          state_q <= round_result_i;
          if (cnt_q == 4'd0) begin
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
            fsm_q   <= S_DONE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_DONE: begin
          if (out_ready_i) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            fsm_q   <= S_IDLE;
          end
        end
        default: begin
          fsm_q <= S_IDLE;
        end
      endcase
    end
  end

  // Round-unit drive is only live in ROUND; quiet zeros elsewhere
  always_comb begin
    round_state_o  = busy_q ? state_q : '0;
    round_key_o    = busy_q ? rk[cnt_q] : '0;
    round_mix_en_o = busy_q && (cnt_q != 4'd0);
  end

  assign in_ready_o  = ready_q;
  assign out_valid_o = valid_q;
  assign plaintext_o = valid_q ? state_q : '0;
  assign busy_o      = busy_q;
  assign round_o     = cnt_q;

endmodule

// File: tb/tb_aes_decrypt_sequencer.sv
// Bench for aes_decrypt_sequencer: an AES-256 instance (default ROUNDS) and an
// AES-128 instance (ROUNDS=10), each closed by a behavioural inverse-round unit.
module tb_aes_decrypt_sequencer;

  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] K256  =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] K128  = 128'h000102030405060708090a0b0c0d0e0f;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // AES-256 instance
  logic          in_valid, in_ready, out_valid, out_ready, rmix, busy;
  logic [127:0]  ct, rstate, rkey, rres, pt;
  logic [1919:0] kc;
  logic [3:0]    rnd;

  // AES-128 instance
  logic          in_valid1, in_ready1, out_valid1, out_ready1, rmix1, busy1;
  logic [127:0]  ct1, rstate1, rkey1, rres1, pt1;
  logic [1407:0] kc1;
  logic [3:0]    rnd1;

  logic [7:0]    sbox  [256];
  logic [7:0]    isbox [256];
  logic [1919:0] chain256, chain128;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int kviol = 0;
  logic [127:0] sb [$];
  logic [127:0] exp_pt;

  aes_decrypt_sequencer u_dut (
    .clk_i(clk), .reset_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .ciphertext_i(ct), .key_chain_i(kc),
    .round_state_o(rstate), .round_key_o(rkey), .round_mix_en_o(rmix),
    .round_result_i(rres),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .plaintext_o(pt),
    .busy_o(busy), .round_o(rnd)
  );

  aes_decrypt_sequencer #(.ROUNDS(10)) u_dut128 (
    .clk_i(clk), .reset_i(rst),
    .in_valid_i(in_valid1), .in_ready_o(in_ready1),
    .ciphertext_i(ct1), .key_chain_i(kc1),
    .round_state_o(rstate1), .round_key_o(rkey1), .round_mix_en_o(rmix1),
    .round_result_i(rres1),
    .out_valid_o(out_valid1), .out_ready_i(out_ready1), .plaintext_o(pt1),
    .busy_o(busy1), .round_o(rnd1)
  );

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] r, aa, bb;
    r = 8'h00; aa = x; bb = y;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) r = r ^ aa;
      aa = xt(aa);
      bb = {1'b0, bb[7:1]};
    end
    return r;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  // FIPS-197 key expansion; w[0] lands at the chain MSBs
  function automatic logic [1919:0] expand(input logic [255:0] key, input int nk);
    logic [31:0]   w [60];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1919:0] ch;
    int nw;
    nw = (nk == 8) ? 60 : 44;
    rc = 8'h01;
    for (int i = 0; i < 60; i++) w[i] = '0;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < nw; i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int i = 0; i < 60; i++) ch[1919-32*i -: 32] = w[i];
    return ch;
  endfunction

  // InvShiftRows, InvSubBytes, AddRoundKey, optional InvMixColumns
  function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic mix);
    logic [7:0]   a [16];
    logic [7:0]   b [16];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) a[i] = s[127-8*i -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        b[r+4*c] = isbox[a[r + 4*((c - r + 4) % 4)]] ^ k[127-8*(r+4*c) -: 8];
    if (mix) begin
      for (int c = 0; c < 4; c++) begin
        a[4*c]   = gm(b[4*c],8'h0e) ^ gm(b[4*c+1],8'h0b) ^ gm(b[4*c+2],8'h0d) ^ gm(b[4*c+3],8'h09);
        a[4*c+1] = gm(b[4*c],8'h09) ^ gm(b[4*c+1],8'h0e) ^ gm(b[4*c+2],8'h0b) ^ gm(b[4*c+3],8'h0d);
        a[4*c+2] = gm(b[4*c],8'h0d) ^ gm(b[4*c+1],8'h09) ^ gm(b[4*c+2],8'h0e) ^ gm(b[4*c+3],8'h0b);
        a[4*c+3] = gm(b[4*c],8'h0b) ^ gm(b[4*c+1],8'h0d) ^ gm(b[4*c+2],8'h09) ^ gm(b[4*c+3],8'h0e);
      end
    end else begin
      for (int i = 0; i < 16; i++) a[i] = b[i];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = a[i];
    return o;
  endfunction

  // Full inverse cipher used as the reference for arbitrary ciphertexts
  function automatic logic [127:0] ref_dec(input logic [127:0] c, input logic [1919:0] ch,
                                           input int nr);
    logic [127:0] s;
    s = c ^ ch[1919-128*nr -: 128];
    for (int r = nr - 1; r >= 0; r--) s = inv_round(s, ch[1919-128*r -: 128], r != 0);
    return s;
  endfunction

  // Behavioural inverse-round units closing each sequencer loop
  always_comb rres  = inv_round(rstate, rkey, rmix);
  always_comb rres1 = inv_round(rstate1, rkey1, rmix1);

  // Key stability monitor: key_chain_i must not move between accept and out_valid
  logic          trk;
  logic [1919:0] kref;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      trk <= 1'b0;
    end else if (in_valid && in_ready) begin
      trk  <= 1'b1;
      kref <= kc;
    end else if (out_valid) begin
      trk <= 1'b0;
    end else if (trk && (kc !== kref)) begin
      kviol <= kviol + 1;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: log handshakes due at the coming edge, then step to next negedge
  task automatic tick();
    if (in_valid && in_ready) sb.push_back(exp_pt);
    if (out_valid && out_ready) begin
      if (sb.size() == 0) chk("sb_underflow", 128'(sb.size()), 128'(1));
      else chk("plaintext", pt, sb.pop_front());
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    out_ready = 1'b1;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk("drain_timeout", 128'(sb.size()), 128'(0));
  endtask

  initial begin
    logic [7:0]   p, q, x;
    logic [127:0] ct2;
    logic [127:0] scts [5];
    int prev, sent, seen, lat;

    p = 8'h01; q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox[0] = 8'h63;
    for (int i = 0; i < 256; i++) isbox[sbox[i]] = i[7:0];
    chain256 = expand(K256, 8);
    chain128 = expand({K128, 128'h0}, 4);

    rst = 1'b1;
    in_valid = 1'b0; ct = '0; kc = chain256; out_ready = 1'b0; exp_pt = '0;
    in_valid1 = 1'b0; ct1 = '0; kc1 = chain128[1919 -: 1408]; out_ready1 = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_round", 128'(rnd), 128'(0));
    chk("rst_plaintext", pt, 128'(0));
    chk("rst_round_key", rkey, 128'(0));
    rst = 1'b0;
    @(negedge clk); cyc++;
    chk("ready_after_rst", 128'(in_ready), 128'(1));
    chk("ready_after_rst_128", 128'(in_ready1), 128'(1));

    // FIPS-197 C.3 known answer with per-round visibility
    ct = CT256; exp_pt = PT; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 14; i++) begin
      chk("kat_round", 128'(rnd), 128'(13 - i));
      chk("kat_mix", 128'(rmix), 128'(i != 13));
      chk("kat_key", rkey, chain256[1919-128*(13-i) -: 128]);
      chk("kat_busy", 128'(busy), 128'(1));
      chk("kat_valid_early", 128'(out_valid), 128'(0));
      tick();
    end
    chk("kat_valid_at_14", 128'(out_valid), 128'(1));
    chk("kat_plaintext", pt, PT);

    // Output backpressure with a second block offered
    ct2 = {$urandom, $urandom, $urandom, $urandom};
    ct = ct2; exp_pt = ref_dec(ct2, chain256, 14); in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      chk("bp_hold_pt", pt, PT);
      chk("bp_in_ready", 128'(in_ready), 128'(0));
      chk("bp_out_valid", 128'(out_valid), 128'(1));
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("bp_idle_ready", 128'(in_ready), 128'(1));
    chk("bp_idle_valid", 128'(out_valid), 128'(0));
    tick();
    chk("bp_second_busy", 128'(busy), 128'(1));
    chk("bp_second_round", 128'(rnd), 128'(13));
    in_valid = 1'b0;
    drain(40);

    // Back-to-back streaming of five blocks
    for (int i = 0; i < 5; i++) scts[i] = {$urandom, $urandom, $urandom, $urandom};
    sent = 0; prev = 0; out_ready = 1'b1;
    ct = scts[0]; exp_pt = ref_dec(scts[0], chain256, 14); in_valid = 1'b1;
    for (int c = 0; c < 200 && (sent < 5 || sb.size() != 0); c++) begin
      if (in_valid && in_ready) begin
        if (sent > 0) chk("stream_spacing", 128'(cyc - prev), 128'(16));
        prev = cyc;
        sent++;
      end
      tick();
      if (sent < 5) begin
        ct = scts[sent];
        exp_pt = ref_dec(scts[sent], chain256, 14);
      end else begin
        in_valid = 1'b0;
      end
    end
    chk("stream_count", 128'(sent), 128'(5));
    chk("stream_drained", 128'(sb.size()), 128'(0));
    chk("key_stable_so_far", 128'(kviol), 128'(0));

    // Asynchronous reset pulse in the middle of round 7
    ct = CT256; exp_pt = PT; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 20 && rnd != 4'd7; c++) tick();
    chk("abort_at_round7", 128'(rnd), 128'(7));
    #2 rst = 1'b1;
    #1;
    chk("abort_in_ready", 128'(in_ready), 128'(0));
    chk("abort_out_valid", 128'(out_valid), 128'(0));
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_round", 128'(rnd), 128'(0));
    chk("abort_plaintext", pt, 128'(0));
    chk("abort_round_state", rstate, 128'(0));
    chk("abort_round_key", rkey, 128'(0));
    chk("abort_mix", 128'(rmix), 128'(0));
    #1 rst = 1'b0;
    sb.delete();
    @(negedge clk); cyc++;
    chk("abort_ready_after", 128'(in_ready), 128'(1));
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      if (out_valid) seen++;
      tick();
    end
    chk("abort_no_valid", 128'(seen), 128'(0));
    ct = CT256; exp_pt = PT; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    drain(40);

    // Key chain changes one cycle after accept
    out_ready = 1'b0;
    ct = CT256; exp_pt = PT; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    kc = '1;
`ifdef AES_DEC_KEY_LATCH_EN
    drain(40);
`else
    sb.delete();
    for (int c = 0; c < 20 && !out_valid; c++) tick();
    chk("nolatch_valid", 128'(out_valid), 128'(1));
    chk("nolatch_key_check_fired", 128'(kviol != 0), 128'(1));
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk); cyc++;
    chk("nolatch_released", 128'(out_valid), 128'(0));
`endif
    kc = chain256;

    // AES-128 build, FIPS-197 C.1
    ct1 = CT128; in_valid1 = 1'b1;
    chk("aes128_ready", 128'(in_ready1), 128'(1));
    @(posedge clk); @(negedge clk); cyc++;
    in_valid1 = 1'b0;
    chk("aes128_first_round", 128'(rnd1), 128'(9));
    lat = 0;
    while (!out_valid1 && lat < 30) begin
      @(posedge clk); @(negedge clk); cyc++;
      lat++;
    end
    chk("aes128_latency", 128'(lat), 128'(10));
    chk("aes128_plaintext", pt1, PT);
    out_ready1 = 1'b1;
    @(posedge clk); @(negedge clk); cyc++;
    chk("aes128_released", 128'(out_valid1), 128'(0));
    chk("aes128_ready_again", 128'(in_ready1), 128'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
